enc_tx_sched: RTL and testbench

- Transmit scheduler in front of the encoding datapath.
- Arbitrates among three packet sources (token, data, handshake) and latches the winner's 99-bit packet image.
- Drives the encoder's pkt/pkt_avail pair until pkt_sent, then enforces an inter-packet gap so the encoder's internal counters return to zero.
- Reports per-requester completion or timeout back to the protocol FSMs.

---
 rtl/enc_tx_sched.sv | 122 ++++++++++++
 tb/tb_enc_tx_sched.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/enc_tx_sched.sv
// Transmit scheduler: arbitrates token/data/handshake packet sources, holds the
// winning 99-bit image on pkt/pkt_avail until pkt_sent or timeout, then gaps.
module enc_tx_sched #(
  parameter int unsigned GAP_CYC     = 2,
  parameter int unsigned TIMEOUT_CYC = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req_valid,
  input  logic [98:0] req_pkt_tok,
  input  logic [98:0] req_pkt_data,
  input  logic [98:0] req_pkt_hs,
  output logic [2:0]  req_ack,
  output logic [2:0]  req_err,
  output logic [98:0] pkt,
  output logic        pkt_avail,
  input  logic        pkt_sent,
  output logic        busy,
  output logic [1:0]  cur_grant
);

  localparam int unsigned PKT_W = 99;
  localparam int unsigned TO_W  = 8;
  localparam int unsigned GAP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t             state;
  logic               tok_pending;
  logic [TO_W-1:0]    to_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [1:0]         win_c;
  logic [PKT_W-1:0]   win_pkt_c;

  // Handshake first; a pending token keeps its DATA packet ahead of the next token.
  always_comb begin
    win_c = 2'd0;
    if (req_valid[2]) begin
      win_c = 2'd2;
    end else if (req_valid[1] && (tok_pending || !req_valid[0])) begin
      win_c = 2'd1;
    end else begin
      win_c = 2'd0;
    end
  end

  always_comb begin
    win_pkt_c = req_pkt_tok;
    case (win_c)
      2'd1:    win_pkt_c = req_pkt_data;
      2'd2:    win_pkt_c = req_pkt_hs;
      default: win_pkt_c = req_pkt_tok;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pkt         <= '0;
      pkt_avail   <= 1'b0;
      req_ack     <= '0;
      req_err     <= '0;
      busy        <= 1'b0;
      cur_grant   <= 2'd3;
      tok_pending <= 1'b0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
    end else begin
      req_ack <= '0;
      req_err <= '0;
      case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            state     <= ST_SEND;
            pkt       <= win_pkt_c;
            cur_grant <= win_c;
            pkt_avail <= 1'b1;
            busy      <= 1'b1;
            to_cnt    <= '0;
            if (win_c != 2'd0) begin
              tok_pending <= 1'b0;
            end
          end
        end
        ST_SEND: begin
          // Completion takes precedence over a coincident timeout.
          if (pkt_sent) begin
            req_ack   <= 3'b001 << cur_grant;
            pkt_avail <= 1'b0;
            gap_cnt   <= '0;
            state     <= ST_GAP;
            if (cur_grant == 2'd0) begin
              tok_pending <= 1'b1;
            end
          end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            req_err   <= 3'b001 << cur_grant;
            pkt_avail <= 1'b0;
            gap_cnt   <= '0;
            state     <= ST_GAP;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            cur_grant <= 2'd3;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enc_tx_sched.sv
// Self-checking bench for enc_tx_sched: directed scenarios plus randomized
// transactions checked against a transaction-level arbitration/timing model.
module tb_enc_tx_sched;

  localparam int unsigned GAP = 2;
  localparam int unsigned TO  = 40;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [98:0] img [3];
  logic [2:0]  req_ack;
  logic [2:0]  req_err;
  logic [98:0] pkt;
  logic        pkt_avail;
  logic        pkt_sent;
  logic        busy;
  logic [1:0]  cur_grant;

  int n_chk;
  int n_fail;
  bit mdl_tokp;

  enc_tx_sched #(.GAP_CYC(GAP), .TIMEOUT_CYC(TO)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_pkt_tok  (img[0]),
    .req_pkt_data (img[1]),
    .req_pkt_hs   (img[2]),
    .req_ack      (req_ack),
    .req_err      (req_err),
    .pkt          (pkt),
    .pkt_avail    (pkt_avail),
    .pkt_sent     (pkt_sent),
    .busy         (busy),
    .cur_grant    (cur_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [98:0] rand99();
    return 99'({$urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  // Arbitration rule: handshake, then data-after-token pairing, else token over data.
  function automatic int mdl_winner(input logic [2:0] r, input bit tp);
    if (r[2]) return 2;
    if (r[1] && r[0]) return tp ? 1 : 0;
    if (r[0]) return 0;
    return 1;
  endfunction

  // One packet from grant to return to IDLE. lat = SEND cycle in which pkt_sent is
  // presented (lat > TO means the encoder never completes).
  task automatic do_txn(input int lat);
    int w;
    int n;
    int exp_n;
    bit exp_ack;
    logic [98:0] exp_pkt;
    w       = mdl_winner(req_valid, mdl_tokp);
    exp_pkt = img[w];
    exp_ack = (lat <= int'(TO));
    exp_n   = exp_ack ? lat : int'(TO);
    tick();
    chk("grant_avail", 128'(pkt_avail), 128'(1));
    chk("grant_idx", 128'(cur_grant), 128'(w));
    chk("grant_pkt", 128'(pkt), 128'(exp_pkt));
    chk("grant_busy", 128'(busy), 128'(1));
    if (w != 0) mdl_tokp = 1'b0;
    n = 0;
    for (int k = 1; k <= int'(TO) + 4; k++) begin
      pkt_sent = (k == lat);
      if (k == 1) begin
        for (int i = 0; i < 3; i++) img[i] = rand99();
        if ($urandom_range(0, 3) == 0) req_valid[w] = 1'b0;
        if ($urandom_range(0, 3) == 0) req_valid = req_valid | 3'($urandom_range(0, 7));
      end
      tick();
      n++;
      if (pkt_avail && k == 1) chk("pkt_frozen", 128'(pkt), 128'(exp_pkt));
      if (!pkt_avail) break;
    end
    pkt_sent = 1'b0;
    chk("avail_len", 128'(n), 128'(exp_n));
    chk("ack_pulse", 128'(req_ack), exp_ack ? 128'(3'b001 << w) : 128'(0));
    chk("err_pulse", 128'(req_err), exp_ack ? 128'(0) : 128'(3'b001 << w));
    req_valid[w] = 1'b0;
    if (w == 0 && exp_ack) mdl_tokp = 1'b1;
    for (int g = 1; g < int'(GAP); g++) begin
      pkt_sent = 1'($urandom_range(0, 1));
      tick();
      chk("gap_pulses", 128'({req_ack, req_err}), 128'(0));
      chk("gap_state", 128'({busy, pkt_avail, cur_grant}), 128'({1'b1, 1'b0, 2'(w)}));
    end
    pkt_sent = 1'b0;
    tick();
    chk("idle_state", 128'({busy, pkt_avail, cur_grant}), 128'({1'b0, 1'b0, 2'd3}));
  endtask

  initial begin
    int w;
    int r;
    int lat;
    n_chk     = 0;
    n_fail    = 0;
    mdl_tokp  = 1'b0;
    rst       = 1'b1;
    req_valid = '0;
    pkt_sent  = 1'b0;
    for (int i = 0; i < 3; i++) img[i] = rand99();
    tick();
    tick();
    chk("rst_outs", 128'({busy, pkt_avail, cur_grant, req_ack, req_err}),
        128'({1'b0, 1'b0, 2'd3, 3'd0, 3'd0}));
    chk("rst_pkt", 128'(pkt), 128'(0));
    rst = 1'b0;
    tick();
    chk("idle_noreq", 128'({busy, pkt_avail}), 128'(0));

    // Single OUT token, encoder done after 32 cycles.
    img[0] = rand99();
    img[0][90:83] = 8'hE1;
    req_valid = 3'b001;
    do_txn(32);

    // All three at once: hs, token, data.
    req_valid = 3'b111;
    do_txn($urandom_range(1, 8));
    do_txn($urandom_range(1, 8));
    do_txn($urandom_range(1, 8));

    // Token completes, then token+data both pending: data must win.
    req_valid = 3'b001;
    do_txn(5);
    req_valid = 3'b011;
    do_txn(3);
    do_txn(3);

    // Timeout with no completion, then completion colliding with timeout.
    req_valid = 3'b010;
    do_txn(int'(TO) + 1);
    req_valid = 3'b100;
    do_txn(int'(TO));

    // Reset during SEND; request held through reset is re-granted afterwards.
    req_valid = 3'b100;
    w = mdl_winner(req_valid, mdl_tokp);
    tick();
    chk("pre_rst_avail", 128'(pkt_avail), 128'(1));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mdl_tokp = 1'b0;
    chk("midrst_outs", 128'({busy, pkt_avail, cur_grant, req_ack, req_err}),
        128'({1'b0, 1'b0, 2'd3, 3'd0, 3'd0}));
    do_txn(4);

    // Randomized traffic.
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < 3; i++) img[i] = rand99();
      req_valid = req_valid | 3'($urandom_range(0, 7));
      if (req_valid == 3'b000) req_valid = 3'($urandom_range(1, 7));
      r = int'($urandom_range(0, 9));
      if (r == 0) lat = int'(TO);
      else if (r == 1) lat = int'(TO) + 1;
      else lat = int'($urandom_range(1, TO - 1));
      do_txn(lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
